// File: rtl/scan_pkg.sv
// Shared types and default widths for the multiple-scan controller.
package scan_pkg;
  localparam int unsigned W_DEF  = 16;
  localparam int unsigned DW_DEF = 4;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;
endpackage

// File: rtl/multiple_scan_ctrl_if.sv
// Valid/ready output stream carrying the emitted multiples.
interface multiple_scan_ctrl_if #(
  parameter int unsigned W = scan_pkg::W_DEF
) ();
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_value;

  modport master (output out_valid, output out_value, input out_ready);
  modport slave  (input out_valid, input out_value, output out_ready);
endinterface

// File: rtl/mod_counter.sv
// Wrapping counter 0..modulus-1; replaces a divider for the i mod divisor test.
module mod_counter
  import scan_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] modulus,
  output logic [DW-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (en) begin
      value <= (value == modulus - DW'(1)) ? '0 : value + DW'(1);
    end
  end

endmodule

// File: rtl/multiple_scan_ctrl.sv
// Walks i over [0, limit) and streams every i with i mod divisor == 0.
module multiple_scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [W-1:0]         limit,
  input  logic [DW-1:0]        divisor,
  multiple_scan_ctrl_if.master out,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [W-1:0]         count
);

  state_t        state;
  logic [W-1:0]  i;
  logic [W-1:0]  limit_r;
  logic [DW-1:0] div_r;
  logic [DW-1:0] m;
  logic          m_zero_c;
  logic          in_range_c;
  logic          m_clr_c;
  logic          m_en_c;

  assign m_zero_c   = (m == '0);
  assign in_range_c = (i < limit_r);
  assign m_clr_c    = (state == IDLE) && start;
  // m advances in lockstep with i: on a skipped candidate or an accepted emission
  assign m_en_c     = ((state == SCAN) && in_range_c && !m_zero_c) ||
                      ((state == EMIT) && out.out_ready);

  mod_counter #(.DW(DW)) u_mod_counter (
    .clk     (clk),
    .rst     (rst),
    .clr     (m_clr_c),
    .en      (m_en_c),
    .modulus (div_r),
    .value   (m)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      out.out_valid <= 1'b0;
      out.out_value <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      count         <= '0;
      i             <= '0;
      limit_r       <= '0;
      div_r         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            limit_r <= limit;
            div_r   <= divisor;
            i       <= '0;
            count   <= '0;
            busy    <= 1'b1;
            if (divisor == '0) begin
              err   <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              err   <= 1'b0;
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (!in_range_c) begin
            done  <= 1'b1;
            state <= DONE;
          end else if (m_zero_c) begin
            out.out_valid <= 1'b1;
            out.out_value <= i;
            state         <= EMIT;
          end else begin
            i <= i + W'(1);
          end
        end
        EMIT: begin
          // out_valid is always high here, so ready alone completes the handshake
          if (out.out_ready) begin
            out.out_valid <= 1'b0;
            count         <= count + W'(1);
            i             <= i + W'(1);
            state         <= SCAN;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
